// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// parity type codes and the fixed line levels of the start and stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity bit placed on the line: XOR of the payload, inverted for odd parity.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity register for the UART transmitter. The parity of a word is computed
// once, at the moment the word is accepted for transmission, so the serializer
// only has to read a single stored bit when it reaches the parity slot.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    logic parity_q;
    logic parity_d;

    // Capture the parity of the incoming word only when a new word is loaded.
    always_comb begin
        parity_d = parity_q;
        if (load_i) begin
            parity_d = parity_bit(^data_i, par_typ_i);
        end
    end

    // Parity storage; cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmitter running on the bit clock: one serial bit per CLK cycle.
// Frame = start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// one stop bit. A word offered while the stop bit is on the line starts the
// next frame immediately, with no idle cycle in between.
// Optional feature: define UART_TX_HOLD_BUF_EN to add a one-entry holding
// buffer that accepts a word while a frame is still being sent.
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Buf_Full
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  load;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_par_en;
    logic                  ld_par_typ;
    logic                  parity;

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_par_en_q, buf_par_en_d;
    logic                  buf_par_typ_q, buf_par_typ_d;
    logic                  buf_full_q, buf_full_d;
`endif

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .load_i   (load),
        .data_i   (ld_data),
        .par_typ_i(ld_par_typ),
        .parity_o (parity)
    );

    // Next-state logic: frame sequencing, word acceptance and the holding buffer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        load       = 1'b0;
        ld_data    = P_DATA;
        ld_par_en  = PAR_EN;
        ld_par_typ = PAR_TYP;
`ifdef UART_TX_HOLD_BUF_EN
        buf_data_d    = buf_data_q;
        buf_par_en_d  = buf_par_en_q;
        buf_par_typ_d = buf_par_typ_q;
        buf_full_d    = buf_full_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    load = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
`ifdef UART_TX_HOLD_BUF_EN
                if (buf_full_q) begin
                    load       = 1'b1;
                    ld_data    = buf_data_q;
                    ld_par_en  = buf_par_en_q;
                    ld_par_typ = buf_par_typ_q;
                    if (Data_Valid) begin
                        buf_data_d    = P_DATA;
                        buf_par_en_d  = PAR_EN;
                        buf_par_typ_d = PAR_TYP;
                    end else begin
                        buf_full_d = 1'b0;
                    end
                end else if (Data_Valid) begin
                    load = 1'b1;
                end
`else
                if (Data_Valid) begin
                    load = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_TX_HOLD_BUF_EN
        if ((state_q == START || state_q == DATA || state_q == PARITY) &&
            Data_Valid && !buf_full_q) begin
            buf_data_d    = P_DATA;
            buf_par_en_d  = PAR_EN;
            buf_par_typ_d = PAR_TYP;
            buf_full_d    = 1'b1;
        end
`endif

        if (load) begin
            state_d  = START;
            cnt_d    = '0;
            data_d   = ld_data;
            par_en_d = ld_par_en;
        end
    end

    // Line level and busy flag for the upcoming cycle, derived from the next state.
    always_comb begin
        tx_d   = STOP_BIT;
        busy_d = (state_d != IDLE);
        unique case (state_d)
            IDLE:    tx_d = STOP_BIT;
            START:   tx_d = START_BIT;
            DATA:    tx_d = data_d[cnt_d];
            PARITY:  tx_d = parity;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = STOP_BIT;
        endcase
    end

    // State, counter, capture registers and registered outputs; reset drops any frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    // Holding buffer registers for the word waiting behind the current frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            buf_data_q    <= '0;
            buf_par_en_q  <= 1'b0;
            buf_par_typ_q <= 1'b0;
            buf_full_q    <= 1'b0;
        end else begin
            buf_data_q    <= buf_data_d;
            buf_par_en_q  <= buf_par_en_d;
            buf_par_typ_q <= buf_par_typ_d;
            buf_full_q    <= buf_full_d;
        end
    end

    assign Buf_Full = buf_full_q;
`else
    assign Buf_Full = 1'b0;
`endif

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench for uart_tx_frame_serializer. The reference model keeps the
// bits still to appear on the line as a queue of frames built from the word,
// and pushes one expected {TX_OUT, Busy, Buf_Full} entry per clock; a separate
// monitor pops and compares one entry after every rising edge.
module tb_uart_tx_frame_serializer;

    localparam int DW = 8;

    typedef struct packed {
        logic tx;
        logic busy;
        logic full;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          TX_OUT;
    logic          Busy;
    logic          Buf_Full;

    exp_t          expQ[$];
    logic          lineQ[$];
    bit            holdFull = 1'b0;
    logic [DW-1:0] holdData = '0;
    logic          holdPe = 1'b0;
    logic          holdPt = 1'b0;
    bit            checkEn = 1'b0;
    int            checkCount = 0;
    int            passCount = 0;

    uart_tx_frame_serializer #(
        .DATA_WIDTH(DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy),
        .Buf_Full  (Buf_Full)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic got, input logic exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Append a whole frame for word d to the model's line queue.
    function automatic void pushFrame(input logic [DW-1:0] d, input logic pe, input logic pt);
        lineQ.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            lineQ.push_back(d[i]);
        end
        if (pe) begin
            lineQ.push_back((^d) ^ pt);
        end
        lineQ.push_back(1'b1);
    endfunction

    // Advance the model across one rising edge that samples the given inputs.
    function automatic void modelEdge(input logic dv, input logic [DW-1:0] d,
                                      input logic pe, input logic pt);
        int   remain;
        exp_t e;
        remain = lineQ.size();
        if (remain > 0) begin
            void'(lineQ.pop_front());
        end
`ifdef UART_TX_HOLD_BUF_EN
        if (remain <= 1) begin
            if (holdFull) begin
                pushFrame(holdData, holdPe, holdPt);
                if (dv) begin
                    holdData = d;
                    holdPe   = pe;
                    holdPt   = pt;
                end else begin
                    holdFull = 1'b0;
                end
            end else if (dv) begin
                pushFrame(d, pe, pt);
            end
        end else if (dv && !holdFull) begin
            holdData = d;
            holdPe   = pe;
            holdPt   = pt;
            holdFull = 1'b1;
        end
`else
        if (remain <= 1 && dv) begin
            pushFrame(d, pe, pt);
        end
`endif
        e.tx   = (lineQ.size() == 0) ? 1'b1 : lineQ[0];
        e.busy = (lineQ.size() != 0);
        e.full = holdFull;
        expQ.push_back(e);
    endfunction

    task automatic applyStimulus(input logic dv, input logic [DW-1:0] d,
                                 input logic pe, input logic pt);
        @(negedge CLK);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        modelEdge(dv, d, pe, pt);
        checkEn = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic doReset(input int cycles);
        @(negedge CLK);
        checkEn    = 1'b0;
        RST        = 1'b0;
        Data_Valid = 1'b0;
        #1;
        checkOutput("reset TX_OUT", TX_OUT, 1'b1);
        checkOutput("reset Busy", Busy, 1'b0);
        checkOutput("reset Buf_Full", Buf_Full, 1'b0);
        lineQ.delete();
        expQ.delete();
        holdFull = 1'b0;
        repeat (cycles) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Monitor: compare the DUT outputs against the scoreboard after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (checkEn) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL scoreboard: no expected entry at %0t", $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("TX_OUT", TX_OUT, e.tx);
                    checkOutput("Busy", Busy, e.busy);
                    checkOutput("Buf_Full", Buf_Full, e.full);
                end
            end
        end
    end

    initial begin
        int guard;
        doReset(2);

        // Plain 8N1 frame of 0xA5.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        idleCycles(12);

        // Even then odd parity on 0x0F.
        applyStimulus(1'b1, 8'h0F, 1'b1, 1'b0);
        idleCycles(12);
        applyStimulus(1'b1, 8'h0F, 1'b1, 1'b1);
        idleCycles(12);

        // Data_Valid held with 0x3C, switched to 0x81 while the stop bit is out.
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        guard = 0;
        while (lineQ.size() != 1 && guard < 50) begin
            applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
            guard++;
        end
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
        idleCycles(14);

        // Hold buffer sequence: 0x11, then 0x22 mid-frame, then 0x33 late.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
        idleCycles(4);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        idleCycles(25);

        // Reset in the middle of data bit 3 of 0xFF.
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        idleCycles(4);
        doReset(2);
        idleCycles(5);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), DW'($urandom),
                          1'($urandom), 1'($urandom));
        end
        idleCycles(30);

        @(posedge CLK);
        #2;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
